// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration-chain loader: the loader
// state encoding, default geometry and a small helper for the tail word.
package fabric_cfg_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_CHAIN_LEN = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SET,
    ST_DONE
  } cfg_ld_state_t;

  // Number of meaningful bits in the last word of a load; a chain that is an
  // exact multiple of the word width ends on a full word.
  function automatic int last_word_len(input int chain_len, input int word_w);
    int rem;
    rem = chain_len % word_w;
    return (rem == 0) ? word_w : rem;
  endfunction

endpackage

// File: rtl/cfg_piso.sv
// Loadable shift register used by the configuration loader. The MSB is the
// serial output toward the chain head; the LSB serial input collects the bits
// that fall out of the chain tail so the same register doubles as readback.
module cfg_piso
  import fabric_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] par_in,
  input  logic              ser_in,
  output logic              ser_out,
  output logic [WORD_W-1:0] par_next
);

  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] shreg_d;

  // Load has priority over shift; shifting moves every bit one place toward
  // the MSB and pulls the serial input into the vacated LSB.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = par_in;
    end else if (shift) begin
      shreg_d = (shreg_q << 1) | WORD_W'(ser_in);
    end
  end

  // Shift register storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_out  = shreg_q[WORD_W-1];
  assign par_next = shreg_d;

endmodule

// File: rtl/cfg_chain_loader.sv
// Configuration-chain master. Takes configuration words over a valid/ready
// stream, serializes them MSB-first onto the fabric shift chain with cfg_cen,
// then strobes cfg_set once so every slice latches its new configuration.
// Optional readback of the old chain contents is built when CFG_READBACK_EN
// is defined; otherwise rd_valid/rd_data stay 0 and cfg_return is ignored.
module cfg_chain_loader
  import fabric_cfg_pkg::*;
#(
  parameter  int WORD_W    = DEF_WORD_W,
  parameter  int CHAIN_LEN = DEF_CHAIN_LEN,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              cfg_cen,
  output logic              cfg_shift,
  output logic              cfg_set,
  input  logic              cfg_return,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data
);

`ifdef CFG_READBACK_EN
  // Bits of padding below a partial final readback word.
  localparam int PAD = WORD_W - last_word_len(CHAIN_LEN, WORD_W);
`endif

  cfg_ld_state_t state_q, state_d;

  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  word_left_q, word_left_d;

  logic              piso_load;
  logic              piso_shift;
  logic              piso_ser_in;
  logic              piso_ser_out;
  logic [WORD_W-1:0] piso_next;

  logic              in_ready_q, in_ready_d;
  logic              cfg_cen_q, cfg_cen_d;
  logic              cfg_shift_q, cfg_shift_d;
  logic              cfg_set_q, cfg_set_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

`ifdef CFG_READBACK_EN
  assign piso_ser_in = cfg_return;
  logic unused_sigs;
  assign unused_sigs = piso_ser_out;
`else
  assign piso_ser_in = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{cfg_return, piso_ser_out, piso_next};
`endif

  cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (piso_load),
    .shift    (piso_shift),
    .par_in   (in_data),
    .ser_in   (piso_ser_in),
    .ser_out  (piso_ser_out),
    .par_next (piso_next)
  );

  // State and counter registers; reset abandons any load in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      word_left_q <= '0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      word_left_q <= word_left_d;
    end
  end

  // Sequencing: accept a word, shift its meaningful bits, repeat until the
  // whole chain is covered, then latch and report completion.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    word_left_d = word_left_q;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          bits_left_d = CNT_W'(CHAIN_LEN);
        end
      end
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          piso_load = 1'b1;
          state_d   = ST_SHIFT;
          if (int'(bits_left_q) >= WORD_W) begin
            word_left_d = CNT_W'(WORD_W);
          end else begin
            word_left_d = bits_left_q;
          end
        end
      end
      ST_SHIFT: begin
        piso_shift  = 1'b1;
        bits_left_d = bits_left_q - CNT_W'(1);
        word_left_d = word_left_q - CNT_W'(1);
        if (word_left_d == '0) begin
          state_d = (bits_left_d == '0) ? ST_SET : ST_LOAD;
        end
      end
      ST_SET: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the state being
  // entered so each output lines up with its state on the pins.
  always_comb begin
    in_ready_d  = (state_d == ST_LOAD);
    cfg_cen_d   = (state_d == ST_SHIFT);
    cfg_shift_d = (state_d == ST_SHIFT) && piso_next[WORD_W-1];
    cfg_set_d   = (state_d == ST_SET);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    rd_valid_d  = 1'b0;
    rd_data_d   = '0;
`ifdef CFG_READBACK_EN
    if ((state_q == ST_SHIFT) && (word_left_d == '0)) begin
      rd_valid_d = 1'b1;
      rd_data_d  = (bits_left_d == '0) ? (piso_next << PAD) : piso_next;
    end
`endif
  end

  // Output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      cfg_cen_q   <= 1'b0;
      cfg_shift_q <= 1'b0;
      cfg_set_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      cfg_cen_q   <= cfg_cen_d;
      cfg_shift_q <= cfg_shift_d;
      cfg_set_q   <= cfg_set_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign cfg_cen   = cfg_cen_q;
  assign cfg_shift = cfg_shift_q;
  assign cfg_set   = cfg_set_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule
